// File: rtl/fifo_wr_ptr_full_pkg.sv
// fifo_wr_ptr_full_pkg: pointer width rule and Gray/binary helpers shared by FIFO pointer blocks
package fifo_wr_ptr_full_pkg;
  localparam int MAXW = 32;
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction
  // Zero-extended operands make these correct for any pointer width up to MAXW
  function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
    logic [MAXW-1:0] b;
    b = g;
    for (int s = 1; s < MAXW; s = s * 2) b = b ^ (b >> s);
    return b;
  endfunction
endpackage

// File: rtl/fifo_wr_ptr_full_gray_to_bin.sv
// gray_to_bin: combinational Gray-to-binary converter for synchronized FIFO pointers
module gray_to_bin
  import fifo_wr_ptr_full_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);
  assign o_bin = W'(gray2bin(MAXW'(i_gray)));
endmodule

// File: rtl/fifo_wr_ptr_full.sv
// fifo_wr_ptr_full: write-domain pointer, full/almost-full, fill level and overflow for an async FIFO
module fifo_wr_ptr_full
  import fifo_wr_ptr_full_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH = FIFO_DEPTH - 2,
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  localparam int PW = ptr_width(ADDR_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic                  OVF_CLR,
  input  logic [PW-1:0]         RD_PTR_SYNC,
  output logic [PW-1:0]         WR_PTR_GRAY,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic                  W_CLKEN,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic [PW-1:0]         FILL_LEVEL,
  output logic                  OVERFLOW
);
  logic [PW-1:0] r_bin, r_gray, r_fill;
  logic          r_full, r_af, r_ovf;
  logic [PW-1:0] w_bin_next, w_gray_next, w_rbin, w_fill_next, w_full_cmp;
  logic          w_push;
  // Writes are dropped during reset so no memory write leaks out of that cycle
  assign w_push = W_INC & ~r_full & ~RST;
  assign w_bin_next = r_bin + PW'(w_push);
  assign w_gray_next = PW'(bin2gray(MAXW'(w_bin_next)));
  assign w_full_cmp = {~RD_PTR_SYNC[ADDR_WIDTH -: 2], RD_PTR_SYNC[ADDR_WIDTH-2:0]};
  assign w_fill_next = w_bin_next - w_rbin;
  gray_to_bin #(.W(PW)) u_g2b (
    .i_gray(RD_PTR_SYNC),
    .o_bin (w_rbin)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_full <= 1'b0;
      r_fill <= '0;
      r_af   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_full <= (w_gray_next == w_full_cmp);
      r_fill <= w_fill_next;
      r_af   <= int'(w_fill_next) >= AF_THRESH;
      r_ovf  <= (W_INC & r_full) | (r_ovf & ~OVF_CLR);
    end
  end
  assign WR_PTR_GRAY = r_gray;
  assign W_ADDR      = r_bin[ADDR_WIDTH-1:0];
  assign W_CLKEN     = w_push;
  assign FULL        = r_full;
  assign ALMOST_FULL = r_af;
  assign FILL_LEVEL  = r_fill;
  assign OVERFLOW    = r_ovf;
endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// tb_fifo_wr_ptr_full: directed scoreboard bench for the write-side pointer/full generator
module tb_fifo_wr_ptr_full;
  typedef struct {
    logic [6:0] m;
    logic [3:0] g;
    logic [2:0] a;
    logic       c;
    logic       f;
    logic       af;
    logic [3:0] l;
    logic       o;
    string      nm;
  } exp_t;
  localparam logic [6:0] ALL = 7'h7f;
  localparam logic [6:0] NOC = 7'h7b;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_inc = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] rd_ptr = 4'b0000;
  logic [3:0] wr_gray;
  logic [2:0] w_addr;
  logic       w_clken, full, almost_full, overflow;
  logic [3:0] fill_level;
  logic [3:0] gt [16];
  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  fifo_wr_ptr_full #(.FIFO_DEPTH(8)) dut (
    .CLK(clk), .RST(rst), .W_INC(w_inc), .OVF_CLR(ovf_clr), .RD_PTR_SYNC(rd_ptr),
    .WR_PTR_GRAY(wr_gray), .W_ADDR(w_addr), .W_CLKEN(w_clken), .FULL(full),
    .ALMOST_FULL(almost_full), .FILL_LEVEL(fill_level), .OVERFLOW(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", nm, fld, act, exp);
    end
  endtask
  // Monitor: every cycle the DUT presents its state; compare against the queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m[0]) chk(e.nm, "gray", wr_gray, e.g);
      if (e.m[1]) chk(e.nm, "addr", {1'b0, w_addr}, {1'b0, e.a});
      if (e.m[2]) chk(e.nm, "clken", {3'b0, w_clken}, {3'b0, e.c});
      if (e.m[3]) chk(e.nm, "full", {3'b0, full}, {3'b0, e.f});
      if (e.m[4]) chk(e.nm, "afull", {3'b0, almost_full}, {3'b0, e.af});
      if (e.m[5]) chk(e.nm, "fill", fill_level, e.l);
      if (e.m[6]) chk(e.nm, "ovf", {3'b0, overflow}, {3'b0, e.o});
    end
  end
  // Drive one cycle's inputs and queue what the DUT should show during that cycle
  task automatic step(input logic r, input logic wi, input logic cl, input logic [3:0] rd,
                      input logic [6:0] m, input logic [3:0] g, input logic [2:0] a, input logic c,
                      input logic f, input logic af, input logic [3:0] l, input logic o, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    w_inc = wi;
    ovf_clr = cl;
    rd_ptr = rd;
    e.m = m; e.g = g; e.a = a; e.c = c; e.f = f; e.af = af; e.l = l; e.o = o; e.nm = nm;
    q.push_back(e);
  endtask
  initial begin
    gt = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
           4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    step(1, 0, 0, 0, 7'h0, 0, 0, 0, 0, 0, 0, 0, "rst0");
    step(1, 1, 0, 0, NOC, 0, 0, 0, 0, 0, 0, 0, "reset");
    for (int k = 0; k < 8; k++)
      step(0, 1, 0, 0, ALL, gt[k], k[2:0], 1, 0, k >= 6, k[3:0], 0, "fill");
    step(0, 1, 0, 0, ALL, 4'b1100, 0, 0, 1, 1, 8, 0, "full");
    step(0, 1, 0, 0, ALL, 4'b1100, 0, 0, 1, 1, 8, 1, "ovf_set");
    step(0, 1, 1, 0, ALL, 4'b1100, 0, 0, 1, 1, 8, 1, "ovf_set_clr");
    step(0, 0, 1, 0, ALL, 4'b1100, 0, 0, 1, 1, 8, 1, "set_wins");
    step(0, 0, 0, 4'b0010, ALL, 4'b1100, 0, 0, 1, 1, 8, 0, "ovf_cleared");
    step(0, 1, 0, 4'b0010, ALL, 4'b1100, 0, 1, 0, 0, 5, 0, "unfull");
    step(0, 0, 0, 4'b0010, ALL, 4'b1101, 1, 0, 0, 1, 6, 0, "write_after");
    step(1, 0, 0, 0, 7'h0, 0, 0, 0, 0, 0, 0, 0, "rst1");
    for (int k = 0; k < 16; k++)
      step(0, 1, 0, gt[(k + 14) % 16], ALL, gt[k], k[2:0], 1, 0, 0, (k == 0) ? 4'd0 : 4'd3, 0, "wrap");
    step(0, 0, 0, gt[14], ALL, 4'b0000, 0, 0, 0, 0, 3, 0, "wrap_end");
    step(1, 0, 0, 0, 7'h0, 0, 0, 0, 0, 0, 0, 0, "rst2");
    for (int k = 0; k < 5; k++)
      step(0, 1, 0, 0, ALL, gt[k], k[2:0], 1, 0, 0, k[3:0], 0, "prefill");
    step(1, 1, 0, 0, NOC, gt[5], 5, 0, 0, 0, 5, 0, "pre_rst");
    step(0, 0, 0, 0, ALL, 4'b0000, 0, 0, 0, 0, 0, 0, "post_rst");
    for (int k = 0; k < 7; k++)
      step(0, 1, 0, 0, ALL, gt[k], k[2:0], 1, 0, k >= 6, k[3:0], 0, "fill7");
    step(0, 1, 0, 4'b0001, ALL, gt[7], 7, 1, 0, 1, 7, 0, "simul");
    step(0, 0, 0, 4'b0001, ALL, 4'b1100, 0, 0, 0, 1, 7, 0, "simul_after");
    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
